imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Pipelined, handshaked immediate generator for the reduced RISC-V datapath.
- Decodes all base immediate formats (I, S, B, U, J) from the full instruction word and sign-extends to XLEN.
- Formats are selected automatically from the opcode or forced by a mode input.
- Sits between fetch/decode and the ALU operand mux. A 2-entry output buffer absorbs back-pressure, and a saturating counter tracks illegal-opcode events.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag (e.g. rd/ROB id) carried alongside the instruction.
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of buffered entries.
- in_valid  in  1  instruction presented.
- in_ready  out  1  block can accept this cycle.
- instr  in  32  instruction word.
- fmt_mode  in  3  0=AUTO, 1=I, 2=S, 3=B, 4=U, 5=J; 6/7 treated as AUTO.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- imm  out  XLEN  sign-extended immediate.
- fmt  out  3  resolved format, same encoding as fmt_mode; 0 = none/illegal.
- illegal  out  1  AUTO mode and opcode not recognised.
- out_tag  out  TAG_W  tag of head entry.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Handshake:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count < 2), purely combinational from state, with no dependence on out_ready. This makes it 1 during and after reset.
- Latency: an instruction accepted at edge t is visible on out_* immediately after edge t (1 cycle) when the buffer was empty.
- Buffer:
  - 2-entry FIFO, order preserved.
  - count 0 → push: count 1.
  - count 1 → push + pop: count stays 1, new entry becomes head on the following cycle.
  - count 2 → push is impossible; pop takes count to 1.
  - out_* reflect the head entry. They are held stable while out_valid && !out_ready.
- AUTO decode by opcode[6:0]:
  - 0000011 / 0010011 / 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111 / 0010111 → U.
  - 1101111 → J.
  - Anything else → fmt=0, imm=0, illegal=1.
- Forced modes ignore the opcode; illegal=0.
- Immediate construction (sign bit is always instr[31], replicated to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Decode happens combinationally on push; the buffer stores the decoded imm, fmt, illegal and tag, not the raw instruction.
- illegal_cnt:
  - Increments by 1 on each push with illegal=1.
  - Saturates at 2^CNT_W-1.
  - Not cleared by flush; only reset clears it.
- flush:
  - Next edge sets count=0 and out_valid=0.
  - A push in the same cycle as flush is discarded, and does not increment illegal_cnt.
  - A pop in the same cycle is irrelevant.
- Reset (async assert, any time including mid-transfer):
  - count=0, out_valid=0, imm=0, fmt=0, illegal=0, out_tag=0, illegal_cnt=0.
  - Storage registers are cleared to 0.

Decomposition:
- Shared package imm_pkg holds:
  - Typedef imm_fmt_e (NONE, I, S, B, U, J).
  - Opcode localparams OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
  - A struct packing {imm, fmt, illegal, tag}.
- One natural sub-module: imm_decode, purely combinational (instr, fmt_mode → imm, fmt, illegal), parametrised on XLEN, reusable by the decoder.
- The FIFO/handshake logic stays in imm_gen_pipe.

Test Plan:
- AUTO, instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 → one cycle later: out_valid=1, imm=0xFFFFFFFF, fmt=I, illegal=0.
- AUTO, 0xFE112E23 (sw x1,-4(x2)) then 0xFE000CE3 (beq -8) back-to-back → imm 0xFFFFFFFC fmt=S, then 0xFFFFFFF8 fmt=B, on consecutive cycles.
- XLEN=32: 0x123452B7 (lui x5,0x12345) → 0x12345000. XLEN=64: lui imm 0x80000 → 0xFFFFFFFF80000000, fmt=U.
- Back-pressure:
  - Stimulus: out_ready=0; push tags 1, 2, 3 on consecutive cycles.
  - in_ready=0 after the 2nd accept; tag 3 is held by the source.
  - Raise out_ready → outputs tags 1, 2, 3 in order; out_* stable while stalled.
- Illegal handling: AUTO 0x0000007F → imm=0, fmt=0, illegal=1, illegal_cnt 0→1. With CNT_W=2, send 5 illegal instructions → illegal_cnt saturates at 3. Forced mode I with the same word → illegal=0, imm=0x00000000.
- Reset and flush:
  - flush with count=2 → out_valid=0 next cycle, illegal_cnt unchanged.
  - rst_n pulsed low mid-stall (asynchronously, between edges) → all outputs 0 immediately, in_ready=1.
  - After rst_n release, the first push behaves as in the first test.

Source files
------------

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and opcode constants for the immediate generator
package imm_pkg;

    // Resolved immediate format; encoding matches the fmt_mode input.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Width-independent part of a buffered entry. The imm and tag fields
    // depend on module parameters, so the full entry struct wraps this one.
    typedef struct packed {
        imm_fmt_e fmt;
        logic     illegal;
    } imm_meta_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RISC-V immediate decoder
//
// Ports:
//   instr    in  32    instruction word
//   fmt_mode in  3     0=AUTO, 1..5 force I/S/B/U/J, 6/7 behave as AUTO
//   imm      out XLEN  sign-extended immediate (0 when illegal)
//   fmt      out 3     resolved format (FMT_NONE when illegal)
//   illegal  out 1     AUTO mode with unrecognised opcode
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      fmt_mode,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [31:0] imm32;

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (fmt_mode)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: fmt = imm_fmt_e'(fmt_mode);
            default: begin
                case (instr[6:0])
                    OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
                    OP_STORE:                 fmt = FMT_S;
                    OP_BRANCH:                fmt = FMT_B;
                    OP_LUI, OP_AUIPC:         fmt = FMT_U;
                    OP_JAL:                   fmt = FMT_J;
                    default:                  illegal = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Bit 31 of every format is instr[31], so extending the 32-bit result
    // reproduces the sign replication for XLEN=64 as well.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - handshaked immediate generator with 2-entry output buffer
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  drop buffered entries and any same-cycle push
//   in_valid/in_ready      instruction handshake (in_ready depends on state only)
//   instr, fmt_mode, in_tag  instruction word, format override, sideband tag
//   out_valid/out_ready    result handshake for the head entry
//   imm, fmt, illegal, out_tag  decoded head entry
//   illegal_cnt            saturating count of accepted illegal instructions
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       fmt_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_meta_t        meta;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    entry_t          new_entry;
    entry_t          slot0;   // head
    entry_t          slot1;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr    (instr),
        .fmt_mode (fmt_mode),
        .imm      (dec_imm),
        .fmt      (dec_fmt),
        .illegal  (dec_illegal)
    );

    always_comb begin
        new_entry              = '0;
        new_entry.imm          = dec_imm;
        new_entry.meta.fmt     = dec_fmt;
        new_entry.meta.illegal = dec_illegal;
        new_entry.tag          = in_tag;
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (pop) begin
            if (count == 2'd2) begin
                // in_ready is low when full, so no push can coincide here.
                slot0 <= slot1;
                count <= 2'd1;
            end else if (push) begin
                slot0 <= new_entry;
            end else begin
                count <= 2'd0;
            end
        end else if (push) begin
            if (count == 2'd0) begin
                slot0 <= new_entry;
            end else begin
                slot1 <= new_entry;
            end
            count <= count + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (push && !flush && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign imm     = slot0.imm;
    assign fmt     = slot0.meta.fmt;
    assign illegal = slot0.meta.illegal;
    assign out_tag = slot0.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN 32 and 64 instances)
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  fmt_mode = '0;
    logic [4:0]  in_tag = '0;

    logic        in_ready_a, out_valid_a, illegal_a;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic [4:0]  out_tag_a;
    logic [1:0]  cnt_a;

    logic        in_ready_b, out_valid_b, illegal_b;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
    logic [4:0]  out_tag_b;
    logic [7:0]  cnt_b;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .instr(instr), .fmt_mode(fmt_mode), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .imm(imm_a), .fmt(fmt_a), .illegal(illegal_a),
        .out_tag(out_tag_a), .illegal_cnt(cnt_a)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .instr(instr), .fmt_mode(fmt_mode), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .imm(imm_b), .fmt(fmt_b), .illegal(illegal_b),
        .out_tag(out_tag_b), .illegal_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    function automatic int classify(input logic [6:0] op);
        case (op)
            7'h03, 7'h13, 7'h67: return 1;
            7'h23:               return 2;
            7'h63:               return 3;
            7'h37, 7'h17:        return 4;
            7'h6F:               return 5;
            default:             return 0;
        endcase
    endfunction

    function automatic exp_t model_entry(input logic [31:0] w, input logic [2:0] m, input logic [4:0] t);
        exp_t   e;
        int     f;
        longint s;
        f = (m >= 3'd1 && m <= 3'd5) ? int'(m) : classify(w[6:0]);
        case (f)
            1: s = $signed(w[31:20]);
            2: s = $signed({w[31:25], w[11:7]});
            3: s = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            4: s = $signed({w[31:12], 12'b0});
            5: s = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default: s = 0;
        endcase
        e.imm = s;
        e.fmt = 3'(f);
        e.ill = (f == 0);
        e.tag = t;
        return e;
    endfunction

    exp_t q[$];
    int   cnt_a_m = 0;
    int   cnt_b_m = 0;
    exp_t new_e;
    bit   acc_m, deq_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cnt_a_m = 0;
            cnt_b_m = 0;
        end else begin
            acc_m = in_valid && (q.size() < 2);
            deq_m = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                new_e = model_entry(instr, fmt_mode, in_tag);
                if (acc_m && new_e.ill) begin
                    if (cnt_a_m < 3)   cnt_a_m++;
                    if (cnt_b_m < 255) cnt_b_m++;
                end
                if (deq_m) void'(q.pop_front());
                if (acc_m) q.push_back(new_e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_a", in_ready_a, q.size() < 2);
            chk("in_ready_b", in_ready_b, q.size() < 2);
            chk("out_valid_a", out_valid_a, q.size() > 0);
            chk("out_valid_b", out_valid_b, q.size() > 0);
            if (q.size() > 0) begin
                chk("imm_a", imm_a, q[0].imm[31:0]);
                chk("imm_b", imm_b, q[0].imm);
                chk("fmt_a", fmt_a, q[0].fmt);
                chk("fmt_b", fmt_b, q[0].fmt);
                chk("illegal_a", illegal_a, q[0].ill);
                chk("tag_a", out_tag_a, q[0].tag);
                chk("tag_b", out_tag_b, q[0].tag);
            end
            chk("cnt_a", cnt_a, cnt_a_m);
            chk("cnt_b", cnt_b, cnt_b_m);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] w, input logic [2:0] m, input logic [4:0] t);
        in_valid = 1'b1;
        instr    = w;
        fmt_mode = m;
        in_tag   = t;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] w, input logic [2:0] m, input logic [4:0] t);
        bit acc;
        int n;
        n = 0;
        drive(w, m, t);
        do begin
            acc = in_ready_a;
            @(negedge clk);
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected accept of tag %0d", t);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_valid_a"}, out_valid_a, 0);
        chk({name, "_valid_b"}, out_valid_b, 0);
        chk({name, "_imm_a"}, imm_a, 0);
        chk({name, "_imm_b"}, imm_b, 0);
        chk({name, "_fmt_a"}, fmt_a, 0);
        chk({name, "_ill_a"}, illegal_a, 0);
        chk({name, "_tag_a"}, out_tag_a, 0);
        chk({name, "_cnt_a"}, cnt_a, 0);
        chk({name, "_cnt_b"}, cnt_b, 0);
        chk({name, "_rdy_a"}, in_ready_a, 1);
        chk({name, "_rdy_b"}, in_ready_b, 1);
    endtask

    initial begin
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // addi x1,x0,-1
        send(32'hFFF00093, 3'd0, 5'd1);
        chk("addi_valid", out_valid_a, 1);
        chk("addi_imm", imm_a, 32'hFFFFFFFF);
        chk("addi_fmt", fmt_a, 1);
        chk("addi_ill", illegal_a, 0);
        @(negedge clk);

        // sw then beq back-to-back
        drive(32'hFE112E23, 3'd0, 5'd2);
        @(negedge clk);
        chk("sw_imm", imm_a, 32'hFFFFFFFC);
        chk("sw_fmt", fmt_a, 2);
        drive(32'hFE000CE3, 3'd0, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        chk("beq_imm", imm_a, 32'hFFFFFFF8);
        chk("beq_fmt", fmt_a, 3);
        @(negedge clk);

        send(32'h123452B7, 3'd0, 5'd4);
        chk("lui_imm", imm_a, 32'h12345000);
        chk("lui_fmt", fmt_a, 4);
        send(32'h800002B7, 3'd0, 5'd5);
        chk("lui64_imm", imm_b, 64'hFFFFFFFF80000000);
        chk("lui64_fmt", fmt_b, 4);
        send(32'h008000EF, 3'd0, 5'd6);
        chk("jal_imm", imm_a, 32'h00000008);
        chk("jal_fmt", fmt_a, 5);
        send(32'hFE112E23, 3'd4, 5'd7);
        chk("forceU_imm", imm_a, 32'hFE112000);
        send(32'hFE112E23, 3'd6, 5'd8);
        chk("mode6_fmt", fmt_a, 2);
        @(negedge clk);

        // back-pressure
        out_ready = 1'b0;
        drive(32'hFFF00093, 3'd0, 5'd9);
        @(negedge clk);
        drive(32'hFE112E23, 3'd0, 5'd10);
        @(negedge clk);
        chk("bp_full_rdy", in_ready_a, 0);
        drive(32'hFE000CE3, 3'd0, 5'd11);
        repeat (2) @(negedge clk);
        chk("bp_stall_tag", out_tag_a, 9);
        chk("bp_stall_imm", imm_a, 32'hFFFFFFFF);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_tag2", out_tag_a, 10);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_tag3", out_tag_a, 11);
        repeat (2) @(negedge clk);

        // illegal handling and saturation
        send(32'h0000007F, 3'd0, 5'd12);
        chk("ill_fmt", fmt_a, 0);
        chk("ill_flag", illegal_a, 1);
        chk("ill_imm", imm_a, 0);
        chk("ill_cnt1", cnt_a, 1);
        for (int i = 0; i < 4; i++) send(32'h0000007F, 3'd0, 5'(13 + i));
        chk("ill_sat_a", cnt_a, 3);
        chk("ill_cnt_b", cnt_b, 5);
        send(32'h0000007F, 3'd1, 5'd17);
        chk("forceI_ill", illegal_a, 0);
        chk("forceI_imm", imm_a, 0);
        chk("forceI_fmt", fmt_a, 1);
        @(negedge clk);

        // flush with two entries, push attempted alongside
        out_ready = 1'b0;
        send(32'hFFF00093, 3'd0, 5'd18);
        send(32'hFE112E23, 3'd0, 5'd19);
        flush = 1'b1;
        drive(32'h0000007F, 3'd0, 5'd20);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush2_valid", out_valid_a, 0);
        chk("flush2_cnt", cnt_b, 5);

        // flush with one entry and a same-cycle illegal push
        send(32'hFFF00093, 3'd0, 5'd21);
        flush = 1'b1;
        drive(32'h0000007F, 3'd0, 5'd22);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush1_valid", out_valid_a, 0);
        chk("flush1_cnt", cnt_b, 5);

        // asynchronous reset mid-stall
        send(32'hFFF00093, 3'd0, 5'd23);
        send(32'hFE112E23, 3'd0, 5'd24);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send(32'hFFF00093, 3'd0, 5'd25);
        chk("post_rst_valid", out_valid_a, 1);
        chk("post_rst_imm", imm_a, 32'hFFFFFFFF);
        chk("post_rst_fmt", fmt_a, 1);
        chk("post_rst_tag", out_tag_a, 25);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
